// File: rtl/ctech_lib_hsk_pkg.sv
// Shared definitions for the ctech_lib toggle-handshake CDC pair (receive side today, transmit side later).
// State encoding and INIT length are fixed here so both ends agree.
package ctech_lib_hsk_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2
  } hsk_state_e;

  localparam int unsigned INIT_CYCLES = 3;

  // Terminal value of the 2-bit INIT counter: INIT ends on the INIT_CYCLES-th edge.
  localparam logic [1:0] INIT_CNT_LAST = 2'(INIT_CYCLES - 1);

  function automatic logic req_pending(input logic req_sync, input logic req_seen);
    return req_sync != req_seen;
  endfunction

endpackage

// File: rtl/ctech_lib_triplesync.sv
// Three-flop level synchroniser for quasi-static signals crossing into the clk domain.
// No reset on purpose: downstream logic masks the output until the chain has flushed.
module ctech_lib_triplesync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] s3_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk) begin
      s1_reg[gi] <= d[gi];
      s2_reg[gi] <= s1_reg[gi];
      s3_reg[gi] <= s2_reg[gi];
    end
  end

  assign q = s3_reg;

endmodule

// File: rtl/ctech_lib_hsk_rx.sv
// Receive side of a toggle request/acknowledge CDC handshake: captures data_in once per req_tgl toggle.
// Optional protocol checker (sticky proto_err port) enabled by macro CTECH_LIB_HSK_RX_PROTO_CHK_EN.
module ctech_lib_hsk_rx
  import ctech_lib_hsk_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] DATA_RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ack_tgl,
  output logic             busy
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
  ,
  output logic             proto_err
`endif
);

  logic             req_sync;
  hsk_state_e       state_reg, state_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic             req_seen_reg, req_seen_next;
  logic             valid_reg, valid_next;
  logic             ack_reg, ack_next;
  logic [WIDTH-1:0] data_reg, data_next;

  ctech_lib_triplesync #(
    .WIDTH (1)
  ) u_req_sync (
    .clk (clk),
    .d   (req_tgl),
    .q   (req_sync)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg    <= INIT;
      cnt_reg      <= '0;
      req_seen_reg <= 1'b0;
      valid_reg    <= 1'b0;
      ack_reg      <= 1'b0;
      data_reg     <= DATA_RST_VAL;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_seen_reg <= req_seen_next;
      valid_reg    <= valid_next;
      ack_reg      <= ack_next;
      data_reg     <= data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_seen_next = req_seen_reg;
    valid_next    = valid_reg;
    ack_next      = ack_reg;
    data_next     = data_reg;
    unique case (state_reg)
      INIT: begin
        // req_sync is not trusted until the synchroniser chain has been flushed.
        if (cnt_reg == INIT_CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      IDLE: begin
        if (req_pending(req_sync, req_seen_reg)) begin
          data_next     = data_in;
          req_seen_next = req_sync;
          valid_next    = 1'b1;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (valid_reg && out_ready) begin
          valid_next = 1'b0;
          ack_next   = ~ack_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign ack_tgl   = ack_reg;
  assign busy      = (state_reg != IDLE);

`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
  logic req_sync_d_reg;
  logic proto_err_reg;

  // A sender must not toggle again before seeing ack; any req_sync movement in HOLD is a violation.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      req_sync_d_reg <= 1'b0;
      proto_err_reg  <= 1'b0;
    end else begin
      req_sync_d_reg <= req_sync;
      if ((state_reg == HOLD) && (req_sync != req_sync_d_reg)) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_reg;
`endif

endmodule

// File: tb/tb_ctech_lib_hsk_rx.sv
// Directed plus modelled-sender bench for ctech_lib_hsk_rx (WIDTH=8, DATA_RST_VAL=0).
// Optional checks on proto_err follow CTECH_LIB_HSK_RX_PROTO_CHK_EN.
module tb_ctech_lib_hsk_rx;

  localparam int WIDTH = 8;
  localparam int NWORDS = 100;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             req_tgl;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ack_tgl;
  logic             busy;
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
  logic             proto_err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  ctech_lib_hsk_rx #(
    .WIDTH        (WIDTH),
    .DATA_RST_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_tgl   (req_tgl),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ack_tgl   (ack_tgl),
    .busy      (busy)
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic [WIDTH-1:0] words [NWORDS];
  logic             v_s, r_s, a_s;
  logic [WIDTH-1:0] d_s;
  int               sent, recv, ack_cnt, cyc;

  initial begin
    rst_b = 1'b0; req_tgl = 1'b0; data_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_valid", out_valid, 0);
    check("rst_ack", ack_tgl, 0);
    check("rst_data", out_data, 8'h00);
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
    check("rst_proto_err", proto_err, 0);
`endif

    // INIT lasts three edges after release
    rst_b = 1'b1;
    tick(); check("init_busy1", busy, 1);
    tick(); check("init_busy2", busy, 1);
    tick(); check("init_busy3", busy, 0);
    check("init_valid", out_valid, 0);
    check("init_ack", ack_tgl, 0);
    $display("reset/init done");

    // A5 with ready high: latency N+3, accepted at N+4
    data_in = 8'hA5; req_tgl = 1'b1; out_ready = 1'b1;
    tick(); check("a5_valid_n", out_valid, 0);
    tick(); check("a5_valid_n1", out_valid, 0);
    tick(); check("a5_valid_n2", out_valid, 0);
    tick(); check("a5_valid_n3", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    check("a5_ack_before", ack_tgl, 0);
    tick(); check("a5_valid_n4", out_valid, 0);
    check("a5_ack_after", ack_tgl, 1);
    check("a5_busy", busy, 0);
    $display("xfer A5 done");

    // 3C held for 10 cycles with ready low
    data_in = 8'h3C; req_tgl = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("3c_valid_early", out_valid, 0);
    tick(); check("3c_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("3c_hold_valid", out_valid, 1);
      check("3c_hold_data", out_data, 8'h3C);
      check("3c_hold_ack", ack_tgl, 1);
    end
    out_ready = 1'b1;
    tick(); check("3c_accept_valid", out_valid, 0);
    check("3c_accept_ack", ack_tgl, 0);
    check("3c_data_kept", out_data, 8'h3C);
    out_ready = 1'b0;
    tick(); check("3c_ack_once", ack_tgl, 0);
    $display("xfer 3C done");

    // toggle during HOLD: data stays, new level picked up in the first IDLE cycle
    data_in = 8'h5A; req_tgl = 1'b1;
    repeat (4) tick();
    check("5a_valid", out_valid, 1);
    check("5a_data", out_data, 8'h5A);
    data_in = 8'hFF; req_tgl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_tgl_data", out_data, 8'h5A);
      check("hold_tgl_valid", out_valid, 1);
    end
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
    check("proto_err_set", proto_err, 1);
`endif
    out_ready = 1'b1;
    tick(); check("5a_accept_valid", out_valid, 0);
    check("5a_accept_ack", ack_tgl, 1);
    tick(); check("ff_b2b_valid", out_valid, 1);
    check("ff_b2b_data", out_data, 8'hFF);
    tick(); check("ff_accept_valid", out_valid, 0);
    check("ff_accept_ack", ack_tgl, 0);
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
    check("proto_err_sticky", proto_err, 1);
`endif
    $display("xfer 5A/FF done");

    // reset in HOLD with ack_tgl=1
    data_in = 8'h77; req_tgl = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    check("77_data", out_data, 8'h77);
    tick(); check("77_ack", ack_tgl, 1);
    data_in = 8'h88; req_tgl = 1'b0; out_ready = 1'b0;
    repeat (4) tick();
    check("88_valid", out_valid, 1);
    check("88_data", out_data, 8'h88);
    rst_b = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ack", ack_tgl, 0);
    check("midrst_data", out_data, 8'h00);
    check("midrst_busy", busy, 1);
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
    check("midrst_proto_err", proto_err, 0);
`endif
    tick(); tick();
    rst_b = 1'b1;
    tick(); check("reinit_busy1", busy, 1);
    tick(); check("reinit_busy2", busy, 1);
    tick(); check("reinit_busy3", busy, 0);
    check("reinit_valid", out_valid, 0);
    $display("mid-transfer reset done");

    // modelled sender, random consumer
    for (int i = 0; i < NWORDS; i++) words[i] = 8'($urandom_range(0, 255));
    sent = 0; recv = 0; ack_cnt = 0; cyc = 0;
    while (recv < NWORDS && cyc < 5000) begin
      if (ack_tgl == req_tgl && sent < NWORDS) begin
        data_in = words[sent];
        req_tgl = ~req_tgl;
        sent++;
      end
      out_ready = 1'($urandom_range(0, 1));
      v_s = out_valid; r_s = out_ready; d_s = out_data; a_s = ack_tgl;
      tick();
      cyc++;
      if (v_s && r_s) begin
        check("rand_word", d_s, words[recv]);
        $display("rand word %0d: %h", recv, d_s);
        recv++;
      end
      if (ack_tgl != a_s) ack_cnt++;
    end
    check("rand_recv_count", recv, NWORDS);
    check("rand_ack_count", ack_cnt, NWORDS);
`ifdef CTECH_LIB_HSK_RX_PROTO_CHK_EN
    check("rand_proto_err", proto_err, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
